mmu_router: RTL
===============

Name: mmu_router

Overview:
- Parametrised successor to the first-generation memory map unit.
- Decodes Vicuna/Ibex data-bus requests into a register-mapped peripheral block (N-channel GPIO, N-channel digital timer) or the storage controller.
- Holds one request outstanding and returns exactly one response (rvalid or err) per accepted request, for both reads and writes.
- Sits between vproc_top and storage_controller, timers and pad GPIO.

Parameters:
MEM_W, 32, data bus width in bits; only 32 is supported.
N_GPIO, 10, number of GPIO pins, 1..32.
N_TIMERS, 1, number of timer channels, 1..8.
PERIPH_BASE, 32'h0000_0100, base address of the peripheral register window.
SRAM_BASE, 32'h0000_1000, first storage address (scratch SRAM).
EXT_BASE, 32'h0000_2000, first external-storage address (read-only).
TIMEOUT_CYCLES, 1024, storage wait limit; used only with the optional feature.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
vproc_mem_req_o  in  1  request strobe, one cycle
vproc_mem_addr_o  in  32  byte address
vproc_mem_we_o  in  1  1 = write
vproc_mem_be_o  in  MEM_W/8  byte enables
vproc_mem_wdata_o  in  MEM_W  write data
vproc_mem_rvalid_i  out  1  response valid (reads and writes)
vproc_mem_err_i  out  1  error response
vproc_mem_rdata_i  out  MEM_W  read data
stor_req  out  1  storage access, held until done
stor_we  out  1  storage write
stor_addr  out  32  latched address
stor_be  out  MEM_W/8  latched byte enables
stor_wdata  out  MEM_W  latched write data
stor_rdata  in  MEM_W  storage read data
stor_valid  in  1  storage done
stor_err  in  1  storage failure
timer_is_high  in  N_TIMERS  per-channel timer status
timer_set_val  out  32*N_TIMERS  channel k occupies bits [32k+31:32k]
set_timer  out  N_TIMERS  one-cycle load pulse
gpio_in  in  N_GPIO  pad inputs (asynchronous)
gpio_out  out  N_GPIO  output register
gpio_oe  out  N_GPIO  1 = drive pad
overlap_err  out  1  sticky: request arrived while busy

Behaviour:
- Reset (rst low, asynchronous): all outputs 0. DIR = 0 (all pins input). OUT = 0. State = IDLE. Any in-flight storage access is abandoned and stor_req drops immediately.
- Register window, word-aligned offsets from PERIPH_BASE:
  - 0x00 DIR: RW, bit i = 1 means pin i is output; gpio_oe = DIR.
  - 0x04 OUT: RW; gpio_out = OUT.
  - 0x08 IN: RO; value from a 2-flop synchroniser on gpio_in.
  - 0x10+4k TIMERk: a write pulses set_timer[k] for one cycle with timer_set_val[k] = wdata; a read returns {31'b0, timer_is_high[k]}.
- Register access rules:
  - Write byte enables mask DIR and OUT per byte.
  - Bits at or above N_GPIO read 0 and ignore writes.
  - A write to OUT for a pin whose DIR bit is 0 is stored but not driven.
- Errors, each a one-cycle err response (rvalid stays 0):
  - Unaligned address (addr[1:0] != 0) in the register window.
  - Unmapped offset in the window.
  - Any address below SRAM_BASE that is outside the window.
  - Write to an address >= EXT_BASE.
  - Write to IN.
- FSM states: IDLE, RESP, STOR_WAIT.
  - IDLE: on req, decode. Register hit or error: perform the side effect at that edge, go to RESP. Storage address: latch addr/we/be/wdata, go to STOR_WAIT.
  - RESP: drive rvalid (or err) and rdata for exactly one cycle, then return to IDLE. Register latency is therefore 1 cycle after req.
  - STOR_WAIT: hold stor_req = 1 with the latched fields stable. If stor_valid or stor_err is seen in cycle n, move to RESP (rdata = stor_rdata captured, err = stor_err), so the response appears in cycle n+1. If stor_valid and stor_err are both high, err wins.
- Requests outside IDLE (including the RESP cycle) are dropped and set overlap_err; it clears only on reset.
- rdata is 0 on every cycle where rvalid = 0.

Optional Feature:
- Macro MMU_ROUTER_TIMEOUT_EN.
- Defined: a 32-bit counter clears on entry to STOR_WAIT and increments each cycle there. On reaching TIMEOUT_CYCLES without stor_valid/stor_err:
  - stor_req drops;
  - FSM goes to RESP with err = 1.
- Undefined: no counter; STOR_WAIT waits indefinitely.

Test Plan:
- Reset, then write DIR = 0x3FF with be = 4'b0011, then write OUT = 0x155 -> gpio_oe = 0x3FF, gpio_out = 0x155, each write answered by rvalid one cycle after req.
- Drive gpio_in = 0x2A5 with DIR = 0, then read IN after 3 cycles -> rdata = 0x2A5, rvalid one cycle after req.
- N_TIMERS = 2: write 0x0000_0064 to PERIPH_BASE+0x14 -> set_timer = 2'b10 for one cycle, timer_set_val[63:32] = 0x64. Read the same address with timer_is_high[1] = 1 -> rdata = 1.
- Read 0x0000_2040 with stor_valid 4 cycles after stor_req, stor_rdata = 0xDEADBEEF -> stor_req high for 4 cycles, rvalid with 0xDEADBEEF next cycle. Write to 0x0000_2040 -> err, stor_req never rises. Read 0x0000_0F00 -> err.
- Issue a req during STOR_WAIT -> dropped, overlap_err = 1. Assert rst low mid-wait -> stor_req 0 immediately, overlap_err 0.
- MMU_ROUTER_TIMEOUT_EN, TIMEOUT_CYCLES = 8, storage never responds -> err one cycle after 8 cycles of stor_req, then IDLE.

Source files
------------

// File: rtl/mmu_router.sv
// Data-bus router: GPIO/timer register window, storage controller pass-through, one response per request.
// Optional storage timeout is enabled by defining MMU_ROUTER_TIMEOUT_EN.
module mmu_router #(
  parameter int unsigned MEM_W          = 32,
  parameter int unsigned N_GPIO         = 10,
  parameter int unsigned N_TIMERS       = 1,
  parameter logic [31:0] PERIPH_BASE    = 32'h0000_0100,
  parameter logic [31:0] SRAM_BASE      = 32'h0000_1000,
  parameter logic [31:0] EXT_BASE       = 32'h0000_2000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vproc_mem_req_o,
  input  logic [31:0]             vproc_mem_addr_o,
  input  logic                    vproc_mem_we_o,
  input  logic [MEM_W/8-1:0]      vproc_mem_be_o,
  input  logic [MEM_W-1:0]        vproc_mem_wdata_o,
  output logic                    vproc_mem_rvalid_i,
  output logic                    vproc_mem_err_i,
  output logic [MEM_W-1:0]        vproc_mem_rdata_i,
  output logic                    stor_req,
  output logic                    stor_we,
  output logic [31:0]             stor_addr,
  output logic [MEM_W/8-1:0]      stor_be,
  output logic [MEM_W-1:0]        stor_wdata,
  input  logic [MEM_W-1:0]        stor_rdata,
  input  logic                    stor_valid,
  input  logic                    stor_err,
  input  logic [N_TIMERS-1:0]     timer_is_high,
  output logic [32*N_TIMERS-1:0]  timer_set_val,
  output logic [N_TIMERS-1:0]     set_timer,
  input  logic [N_GPIO-1:0]       gpio_in,
  output logic [N_GPIO-1:0]       gpio_out,
  output logic [N_GPIO-1:0]       gpio_oe,
  output logic                    overlap_err
);

  localparam logic [31:0] WIN_SIZE = 32'h100;

  typedef enum logic [1:0] {IDLE, RESP, STOR_WAIT} state_e;

  state_e                  state_q;
  logic                    rvalid_q, err_q, stor_req_q, stor_we_q, overlap_q;
  logic [MEM_W-1:0]        rdata_q, stor_wdata_q;
  logic [31:0]             stor_addr_q;
  logic [MEM_W/8-1:0]      stor_be_q;
  logic [N_GPIO-1:0]       dir_q, out_q, sync1_q, sync2_q;
  logic [N_GPIO-1:0]       dir_d, out_d;
  logic [N_TIMERS-1:0]     set_timer_q;
  logic [32*N_TIMERS-1:0]  timer_set_val_q;
`ifdef MMU_ROUTER_TIMEOUT_EN
  logic [31:0]             cnt_q;
`endif

  logic [31:0]             off;
  logic                    in_win, aligned, hit_dir, hit_out, hit_in, hit_tmr;
  logic                    reg_ok, stor_ok, wr_reg, tmr_rd;
  logic [N_TIMERS-1:0]     tmr_sel;
  logic [MEM_W-1:0]        reg_rdata;

  always_comb begin
    off     = vproc_mem_addr_o - PERIPH_BASE;
    in_win  = (vproc_mem_addr_o >= PERIPH_BASE) && (off < WIN_SIZE);
    aligned = (vproc_mem_addr_o[1:0] == 2'b00);
    hit_dir = (off == 32'h0);
    hit_out = (off == 32'h4);
    hit_in  = (off == 32'h8);
    tmr_sel = '0;
    tmr_rd  = 1'b0;
    for (int k = 0; k < N_TIMERS; k++) begin
      if (off == 32'h10 + 32'(4 * k)) begin
        tmr_sel[k] = 1'b1;
        tmr_rd     = timer_is_high[k];
      end
    end
    hit_tmr = |tmr_sel;
    reg_ok  = in_win && aligned &&
              (hit_dir || hit_out || hit_tmr || (hit_in && !vproc_mem_we_o));
    // Storage: everything from SRAM_BASE up, except writes into the read-only external range.
    stor_ok = (vproc_mem_addr_o >= SRAM_BASE) &&
              !(vproc_mem_we_o && (vproc_mem_addr_o >= EXT_BASE));
    wr_reg  = (state_q == IDLE) && vproc_mem_req_o && reg_ok && vproc_mem_we_o;

    reg_rdata = '0;
    if (hit_dir)      reg_rdata[N_GPIO-1:0] = dir_q;
    else if (hit_out) reg_rdata[N_GPIO-1:0] = out_q;
    else if (hit_in)  reg_rdata[N_GPIO-1:0] = sync2_q;
    else if (hit_tmr) reg_rdata[0]          = tmr_rd;

    // Byte-masked GPIO updates; bits at or above N_GPIO simply do not exist.
    dir_d = dir_q;
    out_d = out_q;
    for (int i = 0; i < N_GPIO; i++) begin
      if (wr_reg && hit_dir && vproc_mem_be_o[i/8]) dir_d[i] = vproc_mem_wdata_o[i];
      if (wr_reg && hit_out && vproc_mem_be_o[i/8]) out_d[i] = vproc_mem_wdata_o[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      rvalid_q        <= 1'b0;
      err_q           <= 1'b0;
      rdata_q         <= '0;
      stor_req_q      <= 1'b0;
      stor_we_q       <= 1'b0;
      stor_addr_q     <= '0;
      stor_be_q       <= '0;
      stor_wdata_q    <= '0;
      overlap_q       <= 1'b0;
      dir_q           <= '0;
      out_q           <= '0;
      sync1_q         <= '0;
      sync2_q         <= '0;
      set_timer_q     <= '0;
      timer_set_val_q <= '0;
`ifdef MMU_ROUTER_TIMEOUT_EN
      cnt_q           <= '0;
`endif
    end else begin
      dir_q       <= dir_d;
      out_q       <= out_d;
      sync1_q     <= gpio_in;
      sync2_q     <= sync1_q;
      set_timer_q <= '0;
      if (vproc_mem_req_o && (state_q != IDLE)) overlap_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (vproc_mem_req_o) begin
            if (stor_ok) begin
              stor_req_q   <= 1'b1;
              stor_we_q    <= vproc_mem_we_o;
              stor_addr_q  <= vproc_mem_addr_o;
              stor_be_q    <= vproc_mem_be_o;
              stor_wdata_q <= vproc_mem_wdata_o;
`ifdef MMU_ROUTER_TIMEOUT_EN
              cnt_q        <= '0;
`endif
              state_q      <= STOR_WAIT;
            end else begin
              rvalid_q <= reg_ok;
              err_q    <= !reg_ok;
              rdata_q  <= (reg_ok && !vproc_mem_we_o) ? reg_rdata : '0;
              if (wr_reg && hit_tmr) begin
                set_timer_q <= tmr_sel;
                for (int k = 0; k < N_TIMERS; k++)
                  if (tmr_sel[k]) timer_set_val_q[32*k +: 32] <= vproc_mem_wdata_o;
              end
              state_q <= RESP;
            end
          end
        end
        RESP: begin
          rvalid_q <= 1'b0;
          err_q    <= 1'b0;
          rdata_q  <= '0;
          state_q  <= IDLE;
        end
        STOR_WAIT: begin
          if (stor_valid || stor_err) begin
            stor_req_q <= 1'b0;
            rvalid_q   <= !stor_err;
            err_q      <= stor_err;
            rdata_q    <= stor_err ? '0 : stor_rdata;
            state_q    <= RESP;
          end
`ifdef MMU_ROUTER_TIMEOUT_EN
          else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
            stor_req_q <= 1'b0;
            err_q      <= 1'b1;
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vproc_mem_rvalid_i = rvalid_q;
  assign vproc_mem_err_i    = err_q;
  assign vproc_mem_rdata_i  = rdata_q;
  assign stor_req           = stor_req_q;
  assign stor_we            = stor_we_q;
  assign stor_addr          = stor_addr_q;
  assign stor_be            = stor_be_q;
  assign stor_wdata         = stor_wdata_q;
  assign timer_set_val      = timer_set_val_q;
  assign set_timer          = set_timer_q;
  assign gpio_out           = out_q;
  assign gpio_oe            = dir_q;
  assign overlap_err        = overlap_q;

endmodule
